// File: rtl/sram_resp_pkg.sv
// rtl/sram_resp_pkg.sv - shared constants and byte-merge helper for the data SRAM responder
package sram_resp_pkg;

    localparam logic [15:0] CONF_HI_DEFAULT = 16'hbfaf;

    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_NUM    = 16'hf010;
    localparam logic [15:0] OFF_SWITCH = 16'hf020;
    localparam logic [15:0] OFF_TIMER  = 16'he000;

    function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/byte_we_ram.sv
// rtl/byte_we_ram.sv - single-port word RAM, per-byte write enables, read-first 1-cycle read
module byte_we_ram #(
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**RAM_AW];

    // Contents are deliberately not reset; q reflects the word as it was before this cycle's write.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++)
                if (we[i])
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - CPU data SRAM responder: word RAM plus LED/NUM/SWITCH/TIMER confreg
// Optional TIMER register enabled by defining CONFREG_TIMER_EN.
module data_sram_responder
    import sram_resp_pkg::*;
#(
    parameter int          RAM_AW  = 12,
    parameter logic [15:0] CONF_HI = CONF_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    logic        is_conf;
    logic [15:0] offset;
    logic        conf_wr;
    logic [31:0] ram_q;
    logic [31:0] conf_rd;
    logic [31:0] conf_q;
    logic        region_q;
    logic [31:0] timer_rd;
    logic [15:0] led_next;

    assign is_conf = (data_sram_addr[31:16] == CONF_HI);
    assign offset  = data_sram_addr[15:0];
    assign conf_wr = data_sram_en && is_conf && (data_sram_wen != 4'b0000);

    byte_we_ram #(.RAM_AW(RAM_AW)) u_ram (
        .clk   (clk),
        .en    (data_sram_en && !is_conf),
        .we    (data_sram_wen),
        .addr  (data_sram_addr[RAM_AW+1:2]),
        .wdata (data_sram_wdata),
        .rdata (ram_q)
    );

    always_comb begin
        conf_rd = 32'h0;
        case (offset)
            OFF_LED:    conf_rd = {16'h0, led_out};
            OFF_NUM:    conf_rd = num_out;
            OFF_SWITCH: conf_rd = {24'h0, switch_in};
            OFF_TIMER:  conf_rd = timer_rd;
            default:    conf_rd = 32'h0;
        endcase
    end

    assign led_next = {data_sram_wen[1] ? data_sram_wdata[15:8] : led_out[15:8],
                       data_sram_wen[0] ? data_sram_wdata[7:0]  : led_out[7:0]};

    // Reset parks the output mux on the confreg side so rdata reads 0 without resetting the RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conf_q   <= 32'h0;
            region_q <= 1'b1;
            led_out  <= 16'h0;
            num_out  <= 32'h0;
        end else begin
            if (data_sram_en) begin
                conf_q   <= conf_rd;
                region_q <= is_conf;
            end
            if (conf_wr && offset == OFF_LED)
                led_out <= led_next;
            if (conf_wr && offset == OFF_NUM)
                num_out <= merge_be(num_out, data_sram_wdata, data_sram_wen);
        end
    end

`ifdef CONFREG_TIMER_EN
    logic [31:0] timer;

    // A write cycle replaces the increment rather than adding to it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timer <= 32'h0;
        else if (conf_wr && offset == OFF_TIMER)
            timer <= merge_be(timer, data_sram_wdata, data_sram_wen);
        else
            timer <= timer + 32'h1;
    end

    assign timer_rd = timer;
`else
    assign timer_rd = 32'h0;
`endif

    assign data_sram_rdata = region_q ? conf_q : ram_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - scoreboard bench for data_sram_responder
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  sw = 8'h00;
    logic [15:0] led;
    logic [31:0] num;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic        chk;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] mem_m [int];
    logic [31:0] last_exp;

    data_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch_in       (sw),
        .led_out         (led),
        .num_out         (num)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request cycle; expected rdata is queued at drive time and popped after the edge.
    task automatic acc(input string tag, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic chk, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        en = 1'b1; wen = w; addr = a; wdata = d;
        e.chk = chk; e.val = exp; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        en = 1'b0; wen = 4'h0;
        e = exp_q.pop_front();
        if (e.chk) begin
            check_eq(e.tag, rdata, e.val);
            last_exp = e.val;
        end
    endtask

    task automatic idle(input logic [3:0] w);
        @(negedge clk);
        en = 1'b0; wen = w; addr = 32'h10; wdata = 32'h0;
        @(posedge clk);
        #1;
        wen = 4'h0;
    endtask

    initial begin
        logic [31:0] v, d;
        logic [3:0]  w;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("reset_rdata", rdata, 32'h0);
        check_eq("reset_led", {16'h0, led}, 32'h0);
        check_eq("reset_num", num, 32'h0);

        @(negedge clk);
        en = 1'b1; wen = 4'h0; addr = 32'hbfaf_e000;
        @(posedge clk);
        #1;
        en = 1'b0;
        check_eq("timer_small", {31'h0, rdata <= 32'd8}, 32'h1);

        // RAM, byte lanes, read-first
        acc("ram_w0", 4'hf, 32'h10, 32'hdeadbeef, 1'b0, 32'h0);
        acc("ram_rd", 4'h0, 32'h10, 32'h0, 1'b1, 32'hdeadbeef);
        acc("lane_wr_first", 4'b0101, 32'h10, 32'h11223344, 1'b1, 32'hdeadbeef);
        acc("lane_rd", 4'h0, 32'h10, 32'h0, 1'b1, 32'hde22be44);
        acc("rf_w5", 4'hf, 32'h14, 32'h5, 1'b0, 32'h0);
        acc("rf_w1", 4'hf, 32'h14, 32'h1, 1'b1, 32'h5);
        acc("rf_rd", 4'h0, 32'h14, 32'h0, 1'b1, 32'h1);
        acc("alias_rd", 4'h0, 32'h0001_0010, 32'h0, 1'b1, 32'hde22be44);

        // en=0 with wen set: no write, rdata holds
        idle(4'hf);
        check_eq("hold_rdata", rdata, last_exp);
        acc("nowrite_rd", 4'h0, 32'h10, 32'h0, 1'b1, 32'hde22be44);

        // confreg
        acc("led_wr", 4'hf, 32'hbfaf_f000, 32'h1234_abcd, 1'b1, 32'h0);
        check_eq("led_val", {16'h0, led}, 32'h0000_abcd);
        acc("led_hi_wr", 4'b1100, 32'hbfaf_f000, 32'hffff_ffff, 1'b1, 32'h0000_abcd);
        check_eq("led_hi_ign", {16'h0, led}, 32'h0000_abcd);
        acc("led_b1_wr", 4'b0010, 32'hbfaf_f000, 32'h0000_5500, 1'b1, 32'h0000_abcd);
        acc("led_rd", 4'h0, 32'hbfaf_f000, 32'h0, 1'b1, 32'h0000_55cd);
        sw = 8'h5a;
        acc("sw_rd", 4'h0, 32'hbfaf_f020, 32'h0, 1'b1, 32'h0000_005a);
        acc("sw_wr", 4'hf, 32'hbfaf_f020, 32'h0000_00a5, 1'b1, 32'h0000_005a);
        acc("sw_rd2", 4'h0, 32'hbfaf_f020, 32'h0, 1'b1, 32'h0000_005a);
        acc("num_wr", 4'hf, 32'hbfaf_f010, 32'h1234_5678, 1'b1, 32'h0);
        check_eq("num_val", num, 32'h1234_5678);
        acc("num_wr0", 4'hf, 32'hbfaf_f010, 32'h0, 1'b1, 32'h1234_5678);
        check_eq("num_zero", num, 32'h0);
        acc("unmapped_wr", 4'hf, 32'hbfaf_f030, 32'hffff_ffff, 1'b1, 32'h0);
        acc("unmapped_rd", 4'h0, 32'hbfaf_f030, 32'h0, 1'b1, 32'h0);
        acc("ram_after_conf", 4'h0, 32'h14, 32'h0, 1'b1, 32'h1);

        // timer wrap
        acc("tmr_wr", 4'hf, 32'hbfaf_e000, 32'hffff_fffe, 1'b0, 32'h0);
        idle(4'h0);
`ifdef CONFREG_TIMER_EN
        acc("tmr_rd1", 4'h0, 32'hbfaf_e000, 32'h0, 1'b1, 32'hffff_ffff);
        acc("tmr_wrap", 4'h0, 32'hbfaf_e000, 32'h0, 1'b1, 32'h0);
`else
        acc("tmr_rd1", 4'h0, 32'hbfaf_e000, 32'h0, 1'b1, 32'h0);
        acc("tmr_wrap", 4'h0, 32'hbfaf_e000, 32'h0, 1'b1, 32'h0);
`endif

        // random RAM traffic against a word model
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            mem_m[i] = d;
            acc("rnd_init", 4'hf, 32'h200 + 32'(4 * i), d, 1'b0, 32'h0);
        end
        for (int k = 0; k < 16; k++) begin
            int i;
            i = int'($urandom_range(0, 7));
            d = $urandom;
            w = 4'($urandom);
            v = mem_m[i];
            acc("rnd_wr", w, 32'h200 + 32'(4 * i), d, 1'b1, v);
            for (int b = 0; b < 4; b++)
                if (w[b]) v[8*b +: 8] = d[8*b +: 8];
            mem_m[i] = v;
        end
        for (int i = 0; i < 8; i++)
            acc("rnd_rd", 4'h0, 32'h200 + 32'(4 * i), 32'h0, 1'b1, mem_m[i]);

        // reset mid-run: async clear, RAM retained
        acc("pre_reset_rd", 4'h0, 32'h10, 32'h0, 1'b1, 32'hde22be44);
        acc("led_set", 4'hf, 32'hbfaf_f000, 32'h0000_0f0f, 1'b1, 32'h0000_55cd);
        acc("num_set", 4'hf, 32'hbfaf_f010, 32'h0000_0077, 1'b1, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_reset_rdata", rdata, 32'h0);
        check_eq("mid_reset_led", {16'h0, led}, 32'h0);
        check_eq("mid_reset_num", num, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        acc("ram_retained", 4'h0, 32'h10, 32'h0, 1'b1, 32'hde22be44);
        acc("ram_retained2", 4'h0, 32'h14, 32'h0, 1'b1, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
